// File: rtl/coeff_load_ctrl.sv
// coeff_load_ctrl
// Streams coefficient words from a ready/valid source into the filter chain's
// coefficient stores: 7 segments (fractional decimator, then num/den pairs for
// the three IIR stages), one registered write strobe per accepted word. The
// filter chain is held while a load is in progress.
module coeff_load_ctrl #(
   parameter int unsigned COEFF_WIDTH     = 20,
   parameter int unsigned N_TAP           = 72,
   parameter int unsigned NUM_COEFF_DEPTH = 3,
   parameter int unsigned DEN_COEFF_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          cfg_valid,
   input  logic signed [COEFF_WIDTH-1:0] cfg_data,
   output logic                          cfg_ready,
   output logic [6:0]                    coeff_wr_en,
   output logic signed [COEFF_WIDTH-1:0] coeff_data_out,
   output logic [2:0]                    seg_idx,
   output logic                          chain_hold,
   output logic                          busy,
   output logic                          done
);

   // Longest segment sets the word counter width.
   localparam int unsigned MAX_ND  = (NUM_COEFF_DEPTH > DEN_COEFF_DEPTH) ?
                                     NUM_COEFF_DEPTH : DEN_COEFF_DEPTH;
   localparam int unsigned MAX_LEN = (N_TAP > MAX_ND) ? N_TAP : MAX_ND;
   localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [2:0]  LAST_SEG = 3'd6;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] seg_last;
   logic             xfer;
   logic             last_word;
   logic             last_seg;

   // Index of the final word in the current segment.
   always_comb begin
      seg_last = '0;
      case (seg_idx)
         3'd0:                seg_last = CNT_W'(N_TAP - 1);
         3'd1, 3'd3, 3'd5:    seg_last = CNT_W'(NUM_COEFF_DEPTH - 1);
         default:             seg_last = CNT_W'(DEN_COEFF_DEPTH - 1);
      endcase
   end

   assign last_word = (word_cnt == seg_last);
   assign last_seg  = (seg_idx == LAST_SEG);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; abort dominates a same-cycle final transfer.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (xfer && last_word && last_seg) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State-decoded handshake and status outputs.
   always_comb begin
      cfg_ready  = (state == LOAD) && !abort;
      xfer       = cfg_valid && cfg_ready;
      busy       = (state != IDLE);
      chain_hold = (state != IDLE);
      done       = (state == DONE);
   end

   // Segment / word position; seg_idx stays on the last segment through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
         seg_idx  <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (abort) begin
                  word_cnt <= '0;
                  seg_idx  <= '0;
               end else if (xfer) begin
                  if (last_word) begin
                     word_cnt <= '0;
                     if (!last_seg) begin
                        seg_idx <= seg_idx + 3'd1;
                     end
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            default: begin
               word_cnt <= '0;
               seg_idx  <= '0;
            end
         endcase
      end
   end

   // Registered write port: one strobe per accepted word, data held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coeff_wr_en    <= '0;
         coeff_data_out <= '0;
      end else begin
         coeff_wr_en <= '0;
         if (xfer) begin
            coeff_wr_en    <= 7'b1 << seg_idx;
            coeff_data_out <= cfg_data;
         end
      end
   end

endmodule

// File: tb/tb_coeff_load_ctrl.sv
// tb_coeff_load_ctrl
// Directed bench for coeff_load_ctrl with default parameters (87-word load).
module tb_coeff_load_ctrl;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic               abort;
   logic               cfg_valid;
   logic signed [19:0] cfg_data;
   logic               cfg_ready;
   logic [6:0]         coeff_wr_en;
   logic signed [19:0] coeff_data_out;
   logic [2:0]         seg_idx;
   logic               chain_hold;
   logic               busy;
   logic               done;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [6:0]  wr;
      logic [19:0] data;
      logic        dn;
   } ev_t;

   ev_t mon_q[$];
   int  done_cnt = 0;

   coeff_load_ctrl #(
      .COEFF_WIDTH(20),
      .N_TAP(72),
      .NUM_COEFF_DEPTH(3),
      .DEN_COEFF_DEPTH(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .abort(abort),
      .cfg_valid(cfg_valid),
      .cfg_data(cfg_data),
      .cfg_ready(cfg_ready),
      .coeff_wr_en(coeff_wr_en),
      .coeff_data_out(coeff_data_out),
      .seg_idx(seg_idx),
      .chain_hold(chain_hold),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   // Record every strobe and every done pulse.
   always @(negedge clk) begin
      if (coeff_wr_en != 7'd0) begin
         mon_q.push_back('{wr: coeff_wr_en, data: coeff_data_out, dn: done});
      end
      if (done === 1'b1) begin
         done_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Segment that 1-based word k of a full load belongs to (72,3,2,3,2,3,2).
   function automatic int unsigned exp_seg(input int unsigned k);
      if (k <= 72)      return 0;
      else if (k <= 75) return 1;
      else if (k <= 77) return 2;
      else if (k <= 80) return 3;
      else if (k <= 82) return 4;
      else if (k <= 85) return 5;
      else              return 6;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_wr"},    32'(coeff_wr_en), 32'd0);
      chk({tag, "_data"},  32'(coeff_data_out), 32'd0);
      chk({tag, "_seg"},   32'(seg_idx), 32'd0);
      chk({tag, "_rdy"},   32'(cfg_ready), 32'd0);
      chk({tag, "_hold"},  32'(chain_hold), 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_done"},  32'(done), 32'd0);
   endtask

   // Compare recorded strobes against words 1..n_exp of a full load.
   task automatic chk_mon(input string tag, input int n_exp);
      chk({tag, "_nstrobe"}, 32'(mon_q.size()), 32'(n_exp));
      for (int i = 0; i < mon_q.size() && i < n_exp; i++) begin
         chk($sformatf("%s_wr%0d", tag, i + 1), 32'(mon_q[i].wr), 32'd1 << exp_seg(i + 1));
         chk($sformatf("%s_dat%0d", tag, i + 1), 32'(mon_q[i].data), 32'(i + 1));
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      #1 chk("start_hold_idle", 32'(chain_hold), 32'd0);
      @(negedge clk);
      start = 1'b0;
      #1 chk("start_hold_load", 32'(chain_hold), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
   endtask

   // Back-to-back full load; optionally pulses start in LOAD and DONE, abort in DONE.
   task automatic full_load(input string tag, input bit extras);
      mon_q.delete();
      done_cnt = 0;
      pulse_start();
      for (int k = 1; k <= 87; k++) begin
         cfg_valid = 1'b1;
         cfg_data  = 20'(k);
         start     = extras && (k == 30 || k == 74);
         #1 chk($sformatf("%s_seg%0d", tag, k), 32'(seg_idx), exp_seg(k));
         chk($sformatf("%s_rdy%0d", tag, k), 32'(cfg_ready), 32'd1);
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      start     = extras;
      abort     = extras;
      #1 chk({tag, "_done_cyc"}, 32'(done), 32'd1);
      chk({tag, "_done_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_hold"}, 32'(chain_hold), 32'd1);
      chk({tag, "_done_seg"}, 32'(seg_idx), 32'd6);
      chk({tag, "_done_wr"}, 32'(coeff_wr_en), 32'h40);
      chk({tag, "_done_dat"}, 32'(coeff_data_out), 32'd87);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      #1 chk({tag, "_post_busy"}, 32'(busy), 32'd0);
      chk({tag, "_post_hold"}, 32'(chain_hold), 32'd0);
      chk({tag, "_post_done"}, 32'(done), 32'd0);
      chk({tag, "_post_seg"}, 32'(seg_idx), 32'd0);
      chk({tag, "_post_wr"}, 32'(coeff_wr_en), 32'd0);
      repeat (3) @(negedge clk);
      #1 chk({tag, "_stay_idle"}, 32'(busy), 32'd0);
      chk_mon(tag, 87);
      chk({tag, "_last_dn"}, 32'(mon_q.size() == 87 ? mon_q[86].dn : 1'b0), 32'd1);
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = '0;

      // Reset state, before any clock edge.
      #2 chk_idle_zero("rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1 chk_idle_zero("rst_rel");

      // Full back-to-back load, boundaries checked through seg_idx per word.
      full_load("full", 1'b0);

      // Throttled load with a long gap after word 40.
      mon_q.delete();
      done_cnt = 0;
      pulse_start();
      for (int k = 1; k <= 87; k++) begin
         cfg_valid = 1'b1;
         cfg_data  = 20'(k);
         #1 chk($sformatf("thr_gap_wr%0d", k), 32'(coeff_wr_en), 32'd0);
         chk($sformatf("thr_hold_a%0d", k), 32'(chain_hold), 32'd1);
         @(negedge clk);
         cfg_valid = 1'b0;
         cfg_data  = 20'sd12345;
         #1 chk($sformatf("thr_wr%0d", k), 32'(coeff_wr_en), 32'd1 << exp_seg(k));
         chk($sformatf("thr_dat%0d", k), 32'(coeff_data_out), 32'(k));
         chk($sformatf("thr_hold_b%0d", k), 32'(chain_hold), 32'd1);
         if (k == 40) begin
            repeat (20) begin
               @(negedge clk);
               #1 chk("thr_stall_wr", 32'(coeff_wr_en), 32'd0);
               chk("thr_stall_hold", 32'(chain_hold), 32'd1);
            end
         end
         @(negedge clk);
      end
      #1 chk("thr_end_busy", 32'(busy), 32'd0);
      chk_mon("thr", 87);
      chk("thr_done_cnt", 32'(done_cnt), 32'd1);

      // Abort at seg 3 word 1 (79th word offered).
      mon_q.delete();
      done_cnt = 0;
      pulse_start();
      for (int k = 1; k <= 78; k++) begin
         cfg_valid = 1'b1;
         cfg_data  = 20'(k);
         @(negedge clk);
      end
      abort    = 1'b1;
      cfg_data = 20'sd79;
      #1 chk("abt_rdy", 32'(cfg_ready), 32'd0);
      chk("abt_seg", 32'(seg_idx), 32'd3);
      chk("abt_prev_wr", 32'(coeff_wr_en), 32'h08);
      chk("abt_prev_dat", 32'(coeff_data_out), 32'd78);
      @(negedge clk);
      abort     = 1'b0;
      cfg_valid = 1'b0;
      #1 chk("abt_busy", 32'(busy), 32'd0);
      chk("abt_hold", 32'(chain_hold), 32'd0);
      chk("abt_seg0", 32'(seg_idx), 32'd0);
      chk("abt_no_wr", 32'(coeff_wr_en), 32'd0);
      chk("abt_done", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      chk("abt_done_cnt", 32'(done_cnt), 32'd0);
      chk("abt_nstrobe", 32'(mon_q.size()), 32'd78);

      // Restart after abort begins at seg 0 (negative word exercises sign).
      pulse_start();
      cfg_valid = 1'b1;
      cfg_data  = -20'sd5;
      #1 chk("rs_seg", 32'(seg_idx), 32'd0);
      @(negedge clk);
      cfg_valid = 1'b0;
      #1 chk("rs_wr", 32'(coeff_wr_en), 32'h01);
      chk("rs_dat", 32'(coeff_data_out), 32'hFFFF_FFFB);
      chk("rs_seg_after", 32'(seg_idx), 32'd0);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1 chk("rs_abt_busy", 32'(busy), 32'd0);

      // Start ignored in LOAD/DONE, abort ignored in DONE.
      full_load("ign", 1'b1);

      // start+abort together in IDLE, with cfg_valid high: nothing happens.
      @(negedge clk);
      start     = 1'b1;
      abort     = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 20'sd7;
      @(negedge clk);
      start     = 1'b0;
      abort     = 1'b0;
      #1 chk("sa_busy", 32'(busy), 32'd0);
      chk("sa_hold", 32'(chain_hold), 32'd0);
      chk("sa_rdy", 32'(cfg_ready), 32'd0);
      chk("sa_wr", 32'(coeff_wr_en), 32'd0);
      @(negedge clk);
      cfg_valid = 1'b0;
      #1 chk("sa_wr2", 32'(coeff_wr_en), 32'd0);
      chk("sa_busy2", 32'(busy), 32'd0);

      // Asynchronous reset at seg 0 word 40.
      mon_q.delete();
      pulse_start();
      for (int k = 1; k <= 40; k++) begin
         cfg_valid = 1'b1;
         cfg_data  = 20'(k);
         @(negedge clk);
      end
      cfg_data = 20'sd41;
      #1 chk("mr_pre_wr", 32'(coeff_wr_en), 32'h01);
      chk("mr_pre_dat", 32'(coeff_data_out), 32'd40);
      chk("mr_pre_busy", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1 chk_idle_zero("mr_async");
      cfg_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk_idle_zero("mr_held");
      rst_n = 1'b1;
      @(negedge clk);
      #1 chk_idle_zero("mr_rel");
      chk("mr_nstrobe", 32'(mon_q.size()), 32'd40);

      full_load("post_rst", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
